// File: rtl/input_view_sequencer.sv
// input_view_sequencer
//   Captures one byte plus a 5-bit view mask, then streams the enabled views of
//   that byte one per handshake, lowest view index first.
//
// Ports
//   clk, rst                       clock, synchronous active-high reset
//   in_data, in_mask, in_valid     upstream byte + view select
//   in_ready                       capture possible this cycle
//   flush                          synchronous abort of the current byte
//   out_data, out_view, out_last   current view value, index, last-of-byte flag
//   out_valid, out_ready           downstream handshake
//   busy                           high while emitting views
//   byte_count, drop_count         completed bytes / zero-mask bytes (wrapping)
module input_view_sequencer #(
    parameter int unsigned CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [7:0]       in_data,
    input  logic [4:0]       in_mask,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             flush,
    output logic [7:0]       out_data,
    output logic [2:0]       out_view,
    output logic             out_last,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             busy,
    output logic [CNT_W-1:0] byte_count,
    output logic [CNT_W-1:0] drop_count
);

    typedef enum logic [0:0] {StIdle, StEmit} state_t;

    state_t             state_q, state_d;
    logic [7:0]         data_q, data_d;
    logic [4:0]         mask_q, mask_d;
    logic [7:0]         out_data_q, out_data_d;
    logic [2:0]         out_view_q, out_view_d;
    logic               out_last_q, out_last_d;
    logic               out_valid_q, out_valid_d;
    logic [CNT_W-1:0]   byte_count_q, byte_count_d;
    logic [CNT_W-1:0]   drop_count_q, drop_count_d;

    logic               capture;
    logic               xfer;
    logic [7:0]         src_data;
    logic [4:0]         search_mask;
    logic [2:0]         next_view;
    logic               next_last;

    function automatic logic [7:0] view_of(input logic [7:0] d, input logic [2:0] v);
        logic [7:0] r;
        case (v)
            3'd0:    r = {7'b0, d[3]};
            3'd1:    r = {4'b0, d[5:2]};
            3'd2:    r = d;
            3'd3:    r = {d[5:0], 2'b00};
            3'd4:    r = {4'b0, d[7:4]};
            default: r = 8'h00;
        endcase
        return r;
    endfunction

    assign in_ready = (state_q == StIdle) && !rst && !flush;
    assign capture  = in_valid && in_ready;
    assign xfer     = out_valid_q && out_ready;

    // In IDLE the search runs over the incoming mask; in EMIT over the latched
    // mask restricted to views strictly above the one currently presented.
    always_comb begin
        search_mask = 5'b0;
        src_data    = data_q;
        if (state_q == StIdle) begin
            search_mask = in_mask;
            src_data    = in_data;
        end else begin
            for (int i = 0; i < 5; i++) begin
                if (i > int'(out_view_q)) search_mask[i] = mask_q[i];
            end
        end
    end

    // Lowest enabled view in search_mask, and whether anything lies above it.
    always_comb begin
        next_view = 3'd0;
        next_last = 1'b1;
        for (int i = 4; i >= 0; i--) begin
            if (search_mask[i]) next_view = 3'(i);
        end
        for (int i = 0; i < 5; i++) begin
            if (search_mask[i] && i > int'(next_view)) next_last = 1'b0;
        end
    end

    always_comb begin
        state_d      = state_q;
        data_d       = data_q;
        mask_d       = mask_q;
        out_data_d   = out_data_q;
        out_view_d   = out_view_q;
        out_last_d   = out_last_q;
        out_valid_d  = out_valid_q;
        byte_count_d = byte_count_q;
        drop_count_d = drop_count_q;

        if (flush) begin
            state_d     = StIdle;
            out_valid_d = 1'b0;
            out_last_d  = 1'b0;
            // A final view that still completes its handshake finishes the byte.
            if (xfer && out_last_q) byte_count_d = byte_count_q + 1'b1;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (capture) begin
                        if (in_mask == 5'b0) begin
                            drop_count_d = drop_count_q + 1'b1;
                        end else begin
                            state_d     = StEmit;
                            data_d      = in_data;
                            mask_d      = in_mask;
                            out_valid_d = 1'b1;
                            out_view_d  = next_view;
                            out_data_d  = view_of(src_data, next_view);
                            out_last_d  = next_last;
                        end
                    end
                end
                StEmit: begin
                    if (xfer) begin
                        if (out_last_q) begin
                            state_d      = StIdle;
                            out_valid_d  = 1'b0;
                            out_last_d   = 1'b0;
                            byte_count_d = byte_count_q + 1'b1;
                        end else begin
                            out_view_d = next_view;
                            out_data_d = view_of(src_data, next_view);
                            out_last_d = next_last;
                        end
                    end
                end
                default: state_d = StIdle;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= StIdle;
            data_q       <= 8'h00;
            mask_q       <= 5'b0;
            out_data_q   <= 8'h00;
            out_view_q   <= 3'd0;
            out_last_q   <= 1'b0;
            out_valid_q  <= 1'b0;
            byte_count_q <= '0;
            drop_count_q <= '0;
        end else begin
            state_q      <= state_d;
            data_q       <= data_d;
            mask_q       <= mask_d;
            out_data_q   <= out_data_d;
            out_view_q   <= out_view_d;
            out_last_q   <= out_last_d;
            out_valid_q  <= out_valid_d;
            byte_count_q <= byte_count_d;
            drop_count_q <= drop_count_d;
        end
    end

    assign out_data   = out_data_q;
    assign out_view   = out_view_q;
    assign out_last   = out_last_q;
    assign out_valid  = out_valid_q;
    assign busy       = (state_q == StEmit);
    assign byte_count = byte_count_q;
    assign drop_count = drop_count_q;

endmodule

// File: tb/tb_input_view_sequencer.sv
module tb_input_view_sequencer;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] in_data;
    logic [4:0] in_mask;
    logic       in_valid;
    logic       in_ready;
    logic       flush;
    logic [7:0] out_data;
    logic [2:0] out_view;
    logic       out_last;
    logic       out_valid;
    logic       out_ready;
    logic       busy;
    logic [7:0] byte_count;
    logic [7:0] drop_count;

    int checks   = 0;
    int failures = 0;

    input_view_sequencer #(.CNT_W(8)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_data    (in_data),
        .in_mask    (in_mask),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .flush      (flush),
        .out_data   (out_data),
        .out_view   (out_view),
        .out_last   (out_last),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .busy       (busy),
        .byte_count (byte_count),
        .drop_count (drop_count)
    );

    always #5 clk = ~clk;

    // Advance one clock; inputs are driven and outputs sampled 1 ns after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; in_valid = 1'b0; in_data = 8'h00; in_mask = 5'b0;
        flush = 1'b0; out_ready = 1'b0;
        tick(); tick();
        checks++;
        if (in_ready !== 1'b0) begin
            failures++; $display("FAIL reset_in_ready got=%b exp=0", in_ready);
        end
        checks++;
        if ({out_valid, out_last, busy, out_data, out_view} !== 14'b0) begin
            failures++;
            $display("FAIL reset_outputs got v=%b l=%b b=%b d=%h w=%0d exp all 0",
                     out_valid, out_last, busy, out_data, out_view);
        end
        checks++;
        if (byte_count !== 8'd0 || drop_count !== 8'd0) begin
            failures++;
            $display("FAIL reset_counters got byte=%0d drop=%0d exp=0/0", byte_count, drop_count);
        end
        rst = 1'b0;
        #1;
        checks++;
        if (in_ready !== 1'b1) begin
            failures++; $display("FAIL reset_release_in_ready got=%b exp=1", in_ready);
        end
    endtask

    task automatic test_single_byte();
        logic [7:0] exp_data [5];
        exp_data[0] = 8'h00; exp_data[1] = 8'h0D; exp_data[2] = 8'hB6;
        exp_data[3] = 8'hD8; exp_data[4] = 8'h0B;
        out_ready = 1'b1;
        in_data = 8'hB6; in_mask = 5'b11111; in_valid = 1'b1;
        tick();
        in_valid = 1'b0; in_data = 8'hFF; in_mask = 5'b00001; // ignored in EMIT
        for (int i = 0; i < 5; i++) begin
            checks++;
            if (out_valid !== 1'b1 || busy !== 1'b1 || out_view !== 3'(i) ||
                out_data !== exp_data[i] || out_last !== (i == 4)) begin
                failures++;
                $display("FAIL single_view%0d got v=%b b=%b w=%0d d=%h l=%b exp v=1 b=1 w=%0d d=%h l=%b",
                         i, out_valid, busy, out_view, out_data, out_last, i, exp_data[i], i == 4);
            end
            tick();
        end
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || byte_count !== 8'd1 || busy !== 1'b0) begin
            failures++;
            $display("FAIL single_done got v=%b rdy=%b byte=%0d busy=%b exp v=0 rdy=1 byte=1 busy=0",
                     out_valid, in_ready, byte_count, busy);
        end
    endtask

    task automatic test_backpressure();
        out_ready = 1'b0;
        in_data = 8'hF0; in_mask = 5'b10010; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        for (int k = 0; k < 4; k++) begin
            checks++;
            if (out_valid !== 1'b1 || out_view !== 3'd1 || out_data !== 8'h0C || out_last !== 1'b0) begin
                failures++;
                $display("FAIL stall%0d got v=%b w=%0d d=%h l=%b exp v=1 w=1 d=0c l=0",
                         k, out_valid, out_view, out_data, out_last);
            end
            if (k < 3) tick();
        end
        out_ready = 1'b1;
        tick();
        checks++;
        if (out_valid !== 1'b1 || out_view !== 3'd4 || out_data !== 8'h0F || out_last !== 1'b1) begin
            failures++;
            $display("FAIL sparse_view4 got v=%b w=%0d d=%h l=%b exp v=1 w=4 d=0f l=1",
                     out_valid, out_view, out_data, out_last);
        end
        tick();
        checks++;
        if (out_valid !== 1'b0 || byte_count !== 8'd2) begin
            failures++;
            $display("FAIL sparse_done got v=%b byte=%0d exp v=0 byte=2", out_valid, byte_count);
        end
    endtask

    task automatic test_zero_mask();
        in_data = 8'h5A; in_mask = 5'b0; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        checks++;
        if (out_valid !== 1'b0 || busy !== 1'b0 || drop_count !== 8'd1 || in_ready !== 1'b1) begin
            failures++;
            $display("FAIL zero_mask got v=%b busy=%b drop=%0d rdy=%b exp v=0 busy=0 drop=1 rdy=1",
                     out_valid, busy, drop_count, in_ready);
        end
        tick();
        checks++;
        if (out_valid !== 1'b0 || byte_count !== 8'd2) begin
            failures++;
            $display("FAIL zero_mask_after got v=%b byte=%0d exp v=0 byte=2", out_valid, byte_count);
        end
    endtask

    task automatic test_flush();
        out_ready = 1'b1;
        in_data = 8'hB6; in_mask = 5'b11111; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        tick(); // view0 transferred
        tick(); // view1 transferred, view2 presented
        checks++;
        if (out_view !== 3'd2 || out_valid !== 1'b1) begin
            failures++; $display("FAIL flush_pre got w=%0d v=%b exp w=2 v=1", out_view, out_valid);
        end
        flush = 1'b1;
        tick();
        flush = 1'b0;
        checks++;
        if (out_valid !== 1'b0 || busy !== 1'b0 || byte_count !== 8'd2) begin
            failures++;
            $display("FAIL flush_abort got v=%b busy=%b byte=%0d exp v=0 busy=0 byte=2",
                     out_valid, busy, byte_count);
        end
        // flush in IDLE blocks capture
        flush = 1'b1; in_data = 8'h33; in_mask = 5'b00001; in_valid = 1'b1;
        #1;
        checks++;
        if (in_ready !== 1'b0) begin
            failures++; $display("FAIL flush_idle_ready got=%b exp=0", in_ready);
        end
        tick();
        flush = 1'b0; in_valid = 1'b0;
        checks++;
        if (busy !== 1'b0 || out_valid !== 1'b0) begin
            failures++; $display("FAIL flush_idle_capture got busy=%b v=%b exp 0/0", busy, out_valid);
        end
        in_data = 8'h01; in_mask = 5'b00100; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        checks++;
        if (out_valid !== 1'b1 || out_view !== 3'd2 || out_data !== 8'h01 || out_last !== 1'b1) begin
            failures++;
            $display("FAIL post_flush_byte got v=%b w=%0d d=%h l=%b exp v=1 w=2 d=01 l=1",
                     out_valid, out_view, out_data, out_last);
        end
        tick();
        checks++;
        if (byte_count !== 8'd3 || out_valid !== 1'b0) begin
            failures++; $display("FAIL post_flush_count got byte=%0d v=%b exp 3/0", byte_count, out_valid);
        end
    endtask

    task automatic test_reset_mid_emit();
        out_ready = 1'b1;
        in_data = 8'hB6; in_mask = 5'b11111; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        tick();
        tick();
        out_ready = 1'b0;
        tick();
        checks++;
        if (out_view !== 3'd2 || out_data !== 8'hB6 || out_valid !== 1'b1) begin
            failures++;
            $display("FAIL rst_mid_pre got w=%0d d=%h v=%b exp w=2 d=b6 v=1", out_view, out_data, out_valid);
        end
        rst = 1'b1;
        #1;
        checks++;
        if (in_ready !== 1'b0) begin
            failures++; $display("FAIL rst_mid_ready_high got=%b exp=0", in_ready);
        end
        tick();
        checks++;
        if (out_valid !== 1'b0 || busy !== 1'b0 || byte_count !== 8'd0 || drop_count !== 8'd0 ||
            in_ready !== 1'b0) begin
            failures++;
            $display("FAIL rst_mid got v=%b busy=%b byte=%0d drop=%0d rdy=%b exp 0/0/0/0/0",
                     out_valid, busy, byte_count, drop_count, in_ready);
        end
        rst = 1'b0;
        #1;
        checks++;
        if (in_ready !== 1'b1) begin
            failures++; $display("FAIL rst_mid_release got=%b exp=1", in_ready);
        end
    endtask

    task automatic test_wrap();
        out_ready = 1'b1;
        for (int i = 0; i < 256; i++) begin
            in_data = 8'(i); in_mask = 5'b00001; in_valid = 1'b1;
            tick();
            in_valid = 1'b0;
            if (i == 8) begin
                checks++;
                if (out_data !== 8'h01 || out_last !== 1'b1 || out_view !== 3'd0) begin
                    failures++;
                    $display("FAIL wrap_v0 got d=%h l=%b w=%0d exp d=01 l=1 w=0", out_data, out_last, out_view);
                end
            end
            tick();
            if (i == 254) begin
                checks++;
                if (byte_count !== 8'd255) begin
                    failures++; $display("FAIL wrap_255 got=%0d exp=255", byte_count);
                end
            end
        end
        checks++;
        if (byte_count !== 8'd0 || drop_count !== 8'd0) begin
            failures++;
            $display("FAIL wrap_zero got byte=%0d drop=%0d exp 0/0", byte_count, drop_count);
        end
    endtask

    initial begin
        test_reset();
        test_single_byte();
        test_backpressure();
        test_zero_mask();
        test_flush();
        test_reset_mid_emit();
        test_wrap();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
